// File: rtl/jk_reg_array.sv
// jk_reg_array: WIDTH-bit register with four update modes selected by mode:
//   00 JK (per-bit hold/set/clear/toggle), 01 parallel load, 10 shift, 11 count.
// Ports:
//   clk      - sole clock, rising edge
//   RESET_N  - synchronous active-low reset (q and changed cleared)
//   en       - update enable; q holds when low
//   mode     - operating mode
//   j, k     - per-bit JK inputs (JK mode)
//   d        - parallel load data (load mode)
//   dir      - shift: 0 left / 1 right; count: 0 up / 1 down
//   ser_in   - serial bit entering the vacated position (shift mode)
//   q        - registered state
//   tc       - combinational terminal count (count mode, enabled, at the limit)
//   changed  - registered: q took a different value on the previous edge
module jk_reg_array #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             changed
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  mode_t            mode_e;
  logic [WIDTH-1:0] next_q;
  logic             at_limit;

  assign mode_e = mode_t'(mode);

  // Limit in the current count direction: all-ones going up, zero going down.
  assign at_limit = dir ? (q == '0) : (q == '1);

  assign tc = en && (mode_e == MODE_COUNT) && at_limit;

  always_comb begin
    next_q = q;
    unique case (mode_e)
      MODE_JK: begin
        // Set where j&~k, clear where ~j&k, toggle where j&k, else hold.
        next_q = (j & ~q) | (~k & q);
      end
      MODE_LOAD: begin
        next_q = d;
      end
      MODE_SHIFT: begin
        if (dir)
          next_q = {ser_in, q[WIDTH-1:1]};
        else
          next_q = {q[WIDTH-2:0], ser_in};
      end
      MODE_COUNT: begin
        if (SATURATE && at_limit)
          next_q = q;
        else if (dir)
          next_q = q - WIDTH'(1);
        else
          next_q = q + WIDTH'(1);
      end
      default: next_q = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      q       <= '0;
      changed <= 1'b0;
    end else if (en) begin
      q       <= next_q;
      changed <= (next_q != q);
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jk_reg_array.sv
module tb_jk_reg_array;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             RESET_N;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             dir;
  logic             ser_in;
  logic [WIDTH-1:0] q_w,  q_s;
  logic             tc_w, tc_s;
  logic             ch_w, ch_s;

  int checks = 0;
  int errors = 0;

  jk_reg_array #(.WIDTH(WIDTH), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .RESET_N(RESET_N), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .dir(dir), .ser_in(ser_in), .q(q_w), .tc(tc_w), .changed(ch_w)
  );

  jk_reg_array #(.WIDTH(WIDTH), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .RESET_N(RESET_N), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .dir(dir), .ser_in(ser_in), .q(q_s), .tc(tc_s), .changed(ch_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_both(input logic [WIDTH-1:0] value);
    RESET_N = 1'b1; en = 1'b1; mode = 2'b01; d = value;
    tick();
  endtask

  task automatic test_reset();
    load_both(8'hA5);
    checks++; if (q_w !== 8'hA5) begin errors++; $display("FAIL reset_preload q=%h expected=%h", q_w, 8'hA5); end
    RESET_N = 1'b0; en = 1'b1; mode = 2'b11; dir = 1'b0;
    tick();
    checks++; if (q_w !== 8'h00) begin errors++; $display("FAIL reset_q q=%h expected=00", q_w); end
    checks++; if (ch_w !== 1'b0) begin errors++; $display("FAIL reset_changed changed=%b expected=0", ch_w); end
    checks++; if (q_s !== 8'h00) begin errors++; $display("FAIL reset_q_sat q=%h expected=00", q_s); end
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL reset_tc_up tc=%b expected=0", tc_w); end
    dir = 1'b1; #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL reset_tc_down tc=%b expected=1", tc_w); end
    mode = 2'b00; #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL reset_tc_jk tc=%b expected=0", tc_w); end
    RESET_N = 1'b1; en = 1'b1; mode = 2'b11; dir = 1'b0;
    tick();
    checks++; if (q_w !== 8'h01) begin errors++; $display("FAIL reset_resume q=%h expected=01", q_w); end
  endtask

  task automatic test_jk();
    load_both(8'b1100_1100);
    mode = 2'b00; j = 8'b1010_0000; k = 8'b0110_0000; d = 8'hFF; dir = 1'b1; ser_in = 1'b1;
    tick();
    checks++; if (q_w !== 8'b1010_1100) begin errors++; $display("FAIL jk_q q=%b expected=10101100", q_w); end
    checks++; if (ch_w !== 1'b1) begin errors++; $display("FAIL jk_changed changed=%b expected=1", ch_w); end
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL jk_tc tc=%b expected=0", tc_w); end
    j = 8'h00; k = 8'h00;
    tick();
    checks++; if (q_w !== 8'b1010_1100) begin errors++; $display("FAIL jk_hold q=%b expected=10101100", q_w); end
    checks++; if (ch_w !== 1'b0) begin errors++; $display("FAIL jk_hold_changed changed=%b expected=0", ch_w); end
    j = 8'h0F; k = 8'h0F;
    tick();
    checks++; if (q_w !== 8'b1010_0011) begin errors++; $display("FAIL jk_toggle q=%b expected=10100011", q_w); end
  endtask

  task automatic test_count_wrap();
    load_both(8'hFF);
    mode = 2'b11; dir = 1'b0; #1;
    checks++; if (tc_w !== 1'b1) begin errors++; $display("FAIL wrap_tc_before tc=%b expected=1", tc_w); end
    tick();
    checks++; if (q_w !== 8'h00) begin errors++; $display("FAIL wrap_up q=%h expected=00", q_w); end
    checks++; if (ch_w !== 1'b1) begin errors++; $display("FAIL wrap_up_changed changed=%b expected=1", ch_w); end
    checks++; if (q_s !== 8'hFF) begin errors++; $display("FAIL sat_up_hold q=%h expected=ff", q_s); end
    checks++; if (ch_s !== 1'b0) begin errors++; $display("FAIL sat_up_changed changed=%b expected=0", ch_s); end
    dir = 1'b1;
    tick();
    checks++; if (q_w !== 8'hFF) begin errors++; $display("FAIL wrap_down q=%h expected=ff", q_w); end
    checks++; if (q_s !== 8'hFE) begin errors++; $display("FAIL sat_down_step q=%h expected=fe", q_s); end
    load_both(8'h3C);
    mode = 2'b11; dir = 1'b0;
    tick();
    checks++; if (q_w !== 8'h3D) begin errors++; $display("FAIL count_up q=%h expected=3d", q_w); end
  endtask

  task automatic test_saturate();
    load_both(8'h00);
    mode = 2'b11; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (tc_s !== 1'b1) begin errors++; $display("FAIL sat_tc[%0d] tc=%b expected=1", i, tc_s); end
      tick();
      checks++; if (q_s !== 8'h00) begin errors++; $display("FAIL sat_q[%0d] q=%h expected=00", i, q_s); end
      checks++; if (ch_s !== 1'b0) begin errors++; $display("FAIL sat_changed[%0d] changed=%b expected=0", i, ch_s); end
    end
    load_both(8'hFF);
    mode = 2'b01; #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL tc_load_mode tc=%b expected=0", tc_w); end
    mode = 2'b11; dir = 1'b0; en = 1'b0; #1;
    checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL tc_disabled tc=%b expected=0", tc_w); end
    en = 1'b1;
  endtask

  task automatic test_shift();
    load_both(8'h81);
    mode = 2'b10; dir = 1'b1; ser_in = 1'b0; j = 8'hFF; k = 8'hFF;
    tick();
    checks++; if (q_w !== 8'h40) begin errors++; $display("FAIL shift_right q=%h expected=40", q_w); end
    dir = 1'b0; ser_in = 1'b1;
    tick();
    checks++; if (q_w !== 8'h81) begin errors++; $display("FAIL shift_left q=%h expected=81", q_w); end
    checks++; if (ch_w !== 1'b1) begin errors++; $display("FAIL shift_changed changed=%b expected=1", ch_w); end
  endtask

  task automatic test_hold_load();
    en = 1'b0; mode = 2'b01; d = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (q_w !== 8'h81) begin errors++; $display("FAIL hold_q[%0d] q=%h expected=81", i, q_w); end
      checks++; if (ch_w !== 1'b0) begin errors++; $display("FAIL hold_changed[%0d] changed=%b expected=0", i, ch_w); end
    end
    en = 1'b1;
    tick();
    checks++; if (q_w !== 8'h3C) begin errors++; $display("FAIL load_q q=%h expected=3c", q_w); end
    checks++; if (ch_w !== 1'b1) begin errors++; $display("FAIL load_changed changed=%b expected=1", ch_w); end
    tick();
    checks++; if (ch_w !== 1'b0) begin errors++; $display("FAIL load_equal_changed changed=%b expected=0", ch_w); end
  endtask

  task automatic test_reset_mid();
    load_both(8'h10);
    mode = 2'b11; dir = 1'b0;
    tick();
    checks++; if (q_w !== 8'h11) begin errors++; $display("FAIL mid_count q=%h expected=11", q_w); end
    RESET_N = 1'b0;
    tick();
    checks++; if (q_w !== 8'h00) begin errors++; $display("FAIL mid_reset q=%h expected=00", q_w); end
    RESET_N = 1'b1; mode = 2'b10; dir = 1'b0; ser_in = 1'b1;
    tick();
    checks++; if (q_w !== 8'h01) begin errors++; $display("FAIL mid_resume_shift q=%h expected=01", q_w); end
  endtask

  initial begin
    RESET_N = 1'b0; en = 1'b0; mode = 2'b00;
    j = '0; k = '0; d = '0; dir = 1'b0; ser_in = 1'b0;
    tick();
    tick();
    test_reset();
    test_jk();
    test_count_wrap();
    test_saturate();
    test_shift();
    test_hold_load();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_reg_array.md
JK_REG_ARRAY -- requirements
Module: jk_reg_array

Interface
REQ-001 Parameter WIDTH, default 8, sets the register width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0, selects count overflow behaviour: 0 = wrap, 1 = saturate.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 RESET_N  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 en  input  1  update enable; when 0, q holds.
REQ-006 mode  input  2  operating mode: 00 JK, 01 parallel load, 10 shift, 11 count.
REQ-007 j  input  WIDTH  per-bit J inputs, used in JK mode.
REQ-008 k  input  WIDTH  per-bit K inputs, used in JK mode.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 dir  input  1  direction: shift 0 = left, 1 = right; count 0 = up, 1 = down.
REQ-011 ser_in  input  1  serial bit shifted into the vacated position.
REQ-012 q  output  WIDTH  registered state.
REQ-013 tc  output  1  combinational terminal-count flag.
REQ-014 changed  output  1  registered flag: q changed value on the previous edge.

Function
REQ-015 Every update of q and changed SHALL occur only on the rising edge of clk; there SHALL be no other storage.
REQ-016 When en=0 and RESET_N=1, q SHALL hold and changed SHALL be 0 after the edge.
REQ-017 In JK mode, each bit i SHALL follow its own j[i]/k[i] independently:
- j=0, k=0: hold
- j=1, k=0: set
- j=0, k=1: clear
- j=1, k=1: toggle
REQ-018 In load mode, q SHALL take the value of d on the edge, with 1-cycle latency.
REQ-019 In shift mode with dir=0, q SHALL become {q[WIDTH-2:0], ser_in}.
REQ-020 In shift mode with dir=1, q SHALL become {ser_in, q[WIDTH-1:1]}.
REQ-021 In count mode, q SHALL increment by 1 when dir=0 and decrement by 1 when dir=1; arithmetic is unsigned modulo 2^WIDTH.
REQ-022 In count mode with SATURATE=0, q SHALL wrap from all-ones to 0 (up) and from 0 to all-ones (down).
REQ-023 In count mode with SATURATE=1, q SHALL hold at all-ones (up) or at 0 (down) instead of wrapping.
REQ-024 tc SHALL be 1 only when mode=11, en=1, and either q is all-ones with dir=0 or q=0 with dir=1; tc SHALL be 0 otherwise, including in every other mode.
REQ-025 changed SHALL be 1 for exactly the one cycle after an edge on which the new q differs from the old q; it SHALL be 0 when an update leaves q unchanged (e.g. saturation hold, JK all-hold, load of an equal value).
REQ-026 A change of mode or dir SHALL take effect on the first edge at which it is sampled; there SHALL be no pipeline state and no transitional cycle.
REQ-027 Only the bits j[i], k[i], d, ser_in and dir relevant to the current mode SHALL affect q; unused inputs SHALL be ignored.

Reset
REQ-028 When RESET_N=0 at a rising edge, q SHALL become 0 and changed SHALL become 0, regardless of en, mode or any data input.
REQ-029 Reset SHALL take priority over all modes, including when asserted mid-count or mid-shift; the first edge with RESET_N=1 SHALL resume normal operation from q=0.
REQ-030 While RESET_N=0, tc SHALL follow REQ-024 using q=0; with the default mode=00, tc=0.

Verification
REQ-031 Reset: WIDTH=8, q=8'hA5, RESET_N=0 for one edge with en=1, mode=11 -> q=8'h00, changed=0.
REQ-032 JK: q=8'b1100_1100, j=8'b1010_0000, k=8'b0110_0000, en=1 -> q=8'b1010_1100, changed=1.
REQ-033 Count wrap: SATURATE=0, q=8'hFF, mode=11, dir=0 -> tc=1 before the edge; q=8'h00 and changed=1 after it. Then dir=1 -> q=8'hFF.
REQ-034 Count saturate: SATURATE=1, q=8'h00, mode=11, dir=1 -> tc=1, q stays 8'h00, changed=0 for 3 consecutive edges.
REQ-035 Shift: q=8'h81, mode=10, dir=1, ser_in=0 -> 8'h40; then dir=0, ser_in=1 -> 8'h81.
REQ-036 Hold and load: en=0 with mode=01, d=8'h3C for 2 edges -> q unchanged, changed=0; then en=1 -> q=8'h3C, changed=1 one cycle later.
